// File: rtl/nc_adapt_controller.sv
// Noise-cancellation sequencing controller: IIR/LMS gating, step-size schedule, convergence tracking.
// Optional feature: define NC_DIVERGE_RESTART_EN to restart from WARMUP on divergence instead of HOLD.
module nc_adapt_controller #(
  parameter int unsigned WARMUP_LEN = 32,
  parameter int unsigned CONV_CNT   = 64,
  parameter logic [15:0] TH_CONV    = 16'd256,
  parameter logic [15:0] TH_DIV     = 16'd16384,
  parameter logic [3:0]  MU_FAST    = 4'd4,
  parameter logic [3:0]  MU_SLOW    = 4'd8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic signed [15:0] err,
  output logic               iir_en,
  output logic               lms_en,
  output logic [3:0]         mu_shift,
  output logic               coef_clear,
  output logic               out_sel,
  output logic               converged,
  output logic [2:0]         state,
  output logic [7:0]         div_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ADAPT  = 3'd2,
    S_TRACK  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  localparam logic [7:0]  WARM_LAST = 8'(WARMUP_LEN - 1);
  localparam logic [7:0]  CONV_LAST = 8'(CONV_CNT - 1);
  localparam logic [16:0] TH_HYST   = {TH_CONV, 1'b0};

  state_e      state_q, state_d;
  logic [15:0] avg_q, avg_d;
  logic [7:0]  smp_cnt_q, smp_cnt_d;
  logic [7:0]  conv_cnt_q, conv_cnt_d;
  logic [7:0]  div_count_q, div_count_d;
  logic        coef_clear_q, coef_clear_d;
  logic        iir_en_q, iir_en_d;
  logic        lms_en_q, lms_en_d;
  logic        out_sel_q, out_sel_d;
  logic        converged_q, converged_d;
  logic [3:0]  mu_shift_q, mu_shift_d;

  logic [15:0]        mag;
  logic signed [16:0] diff;
  logic signed [16:0] avg_sum;
  logic [15:0]        avg_nxt;
  logic               diverge;

  always_comb begin
    if (err == 16'sh8000)
      mag = 16'h7fff;
    else if (err[15])
      mag = $unsigned(-err);
    else
      mag = $unsigned(err);
    diff    = $signed({1'b0, mag}) - $signed({1'b0, avg_q});
    avg_sum = $signed({1'b0, avg_q}) + (diff >>> 4);
    avg_nxt = avg_sum[15:0];
  end

  // Thresholds compare against avg_q (pre-update); the updated average only lands next cycle.
  always_comb begin
    state_d      = state_q;
    avg_d        = avg_q;
    smp_cnt_d    = smp_cnt_q;
    conv_cnt_d   = conv_cnt_q;
    div_count_d  = div_count_q;
    coef_clear_d = 1'b0;
    diverge      = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_WARMUP;
          coef_clear_d = 1'b1;
          avg_d        = '0;
          smp_cnt_d    = '0;
        end
        S_WARMUP: begin
          if (sample_valid) begin
            if (smp_cnt_q == WARM_LAST) begin
              state_d    = S_ADAPT;
              conv_cnt_d = '0;
            end else begin
              smp_cnt_d = smp_cnt_q + 8'd1;
            end
          end
        end
        S_ADAPT: begin
          if (sample_valid) begin
            avg_d = avg_nxt;
            if (avg_q >= TH_DIV) begin
              diverge = 1'b1;
            end else if (avg_q < TH_CONV) begin
              if (conv_cnt_q == CONV_LAST)
                state_d = S_TRACK;
              else
                conv_cnt_d = conv_cnt_q + 8'd1;
            end else begin
              conv_cnt_d = '0;
            end
          end
        end
        S_TRACK: begin
          if (sample_valid) begin
            avg_d = avg_nxt;
            if (avg_q >= TH_DIV) begin
              diverge = 1'b1;
            end else if ({1'b0, avg_q} >= TH_HYST) begin
              state_d    = S_ADAPT;
              conv_cnt_d = '0;
            end
          end
        end
        S_HOLD: state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
    if (diverge) begin
      if (div_count_q != 8'hff)
        div_count_d = div_count_q + 8'd1;
`ifdef NC_DIVERGE_RESTART_EN
      state_d      = S_WARMUP;
      coef_clear_d = 1'b1;
      avg_d        = '0;
      smp_cnt_d    = '0;
`else
      state_d = S_HOLD;
`endif
    end
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    iir_en_d    = 1'b0;
    lms_en_d    = 1'b0;
    out_sel_d   = 1'b0;
    converged_d = 1'b0;
    mu_shift_d  = '0;
    case (state_d)
      S_WARMUP, S_HOLD: iir_en_d = 1'b1;
      S_ADAPT: begin
        iir_en_d   = 1'b1;
        lms_en_d   = 1'b1;
        out_sel_d  = 1'b1;
        mu_shift_d = MU_FAST;
      end
      S_TRACK: begin
        iir_en_d    = 1'b1;
        lms_en_d    = 1'b1;
        out_sel_d   = 1'b1;
        converged_d = 1'b1;
        mu_shift_d  = MU_SLOW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      avg_q        <= '0;
      smp_cnt_q    <= '0;
      conv_cnt_q   <= '0;
      div_count_q  <= '0;
      coef_clear_q <= 1'b0;
      iir_en_q     <= 1'b0;
      lms_en_q     <= 1'b0;
      out_sel_q    <= 1'b0;
      converged_q  <= 1'b0;
      mu_shift_q   <= '0;
    end else begin
      state_q      <= state_d;
      avg_q        <= avg_d;
      smp_cnt_q    <= smp_cnt_d;
      conv_cnt_q   <= conv_cnt_d;
      div_count_q  <= div_count_d;
      coef_clear_q <= coef_clear_d;
      iir_en_q     <= iir_en_d;
      lms_en_q     <= lms_en_d;
      out_sel_q    <= out_sel_d;
      converged_q  <= converged_d;
      mu_shift_q   <= mu_shift_d;
    end
  end

  assign state      = state_q;
  assign iir_en     = iir_en_q;
  assign lms_en     = lms_en_q;
  assign out_sel    = out_sel_q;
  assign converged  = converged_q;
  assign mu_shift   = mu_shift_q;
  assign coef_clear = coef_clear_q;
  assign div_count  = div_count_q;

endmodule

// File: tb/tb_nc_adapt_controller.sv
// Self-checking bench for nc_adapt_controller: vector table plus multi-cycle sequences.
module tb_nc_adapt_controller;

  logic               clk = 1'b0;
  logic               rst, enable, sample_valid;
  logic signed [15:0] err;
  logic               iir_en, lms_en, coef_clear, out_sel, converged;
  logic [3:0]         mu_shift;
  logic [2:0]         state;
  logic [7:0]         div_count;

  int tests = 0;
  int fails = 0;
  logic [15:0] avg_m;

  always #5 clk = ~clk;

  nc_adapt_controller #(
    .WARMUP_LEN(32),
    .CONV_CNT  (64),
    .TH_CONV   (16'd256),
    .TH_DIV    (16'd16384),
    .MU_FAST   (4'd4),
    .MU_SLOW   (4'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .err         (err),
    .iir_en      (iir_en),
    .lms_en      (lms_en),
    .mu_shift    (mu_shift),
    .coef_clear  (coef_clear),
    .out_sel     (out_sel),
    .converged   (converged),
    .state       (state),
    .div_count   (div_count)
  );

  typedef struct {
    logic               r;
    logic               en;
    logic               sv;
    logic signed [15:0] e;
    int                 n;
    logic [2:0]         st;
    logic               cc;
    logic [7:0]         dc;
  } vec_t;

  vec_t tbl[9];

  // {iir_en, lms_en, out_sel, converged, mu_shift} for each state
  function automatic logic [7:0] dec(input logic [2:0] s);
    case (s)
      3'd1, 3'd4: return 8'b1000_0000;
      3'd2:       return {4'b1110, 4'd4};
      3'd3:       return {4'b1111, 4'd8};
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] upd(input logic [15:0] a, input logic signed [15:0] e);
    int m, d;
    if (e == -16'sd32767 - 16'sd1) m = 32767;
    else if (e < 0) m = -int'(e);
    else m = int'(e);
    d = m - int'(a);
    return 16'(int'(a) + (d >>> 4));
  endfunction

  task automatic cyc(input logic r, input logic en, input logic sv, input logic signed [15:0] e);
    rst = r; enable = en; sample_valid = sv; err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] es, input logic ec, input logic [7:0] ed);
    logic [7:0] eo, act;
    eo  = dec(es);
    act = {iir_en, lms_en, out_sel, converged, mu_shift};
    tests++;
    if (state !== es || act !== eo || coef_clear !== ec || div_count !== ed) begin
      fails++;
      $display("FAIL %s: state=%0d want %0d, outs=%b want %b, coef_clear=%b want %b, div_count=%0d want %0d",
               nm, state, es, act, eo, coef_clear, ec, div_count, ed);
    end
  endtask

  task automatic diverge_seq(input string nm, input logic [7:0] ed);
    bit pred, found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pred = (avg_m >= 16'd16384);
      cyc(1'b0, 1'b1, 1'b1, 16'sh8000);
      avg_m = upd(avg_m, 16'sh8000);
      if (pred) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: avg never reached divergence threshold, state=%0d", nm, state);
    end
`ifdef NC_DIVERGE_RESTART_EN
    check(nm, 3'd1, 1'b1, ed);
    avg_m = '0;
`else
    check(nm, 3'd4, 1'b0, ed);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pred, found;
    //         rst   en    sv    err   n   st    cc    dc
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'sd0, 2,  3'd0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'sd0, 3,  3'd0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'sd0, 1,  3'd1, 1'b1, 8'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 16'sd0, 1,  3'd1, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'sd0, 31, 3'd1, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'sd0, 1,  3'd2, 1'b0, 8'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'sd0, 3,  3'd2, 1'b0, 8'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'sd0, 63, 3'd2, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 16'sd0, 1,  3'd3, 1'b0, 8'd0};

    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; err = '0;
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < tbl[v].n; k++)
        cyc(tbl[v].r, tbl[v].en, tbl[v].sv, tbl[v].e);
      check($sformatf("vec%0d", v), tbl[v].st, tbl[v].cc, tbl[v].dc);
    end

    // TRACK with moderate error stays put; larger error crosses the hysteresis level
    avg_m = '0;
    repeat (100) begin
      cyc(1'b0, 1'b1, 1'b1, 16'sd300);
      avg_m = upd(avg_m, 16'sd300);
    end
    check("track_err300", 3'd3, 1'b0, 8'd0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      pred = (avg_m >= 16'd512);
      cyc(1'b0, 1'b1, 1'b1, 16'sd1000);
      avg_m = upd(avg_m, 16'sd1000);
      if (pred) begin
        found = 1'b1;
        break;
      end
      check("track_err1000", 3'd3, 1'b0, 8'd0);
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL hyst_timeout: avg never reached 512, state=%0d", state);
    end
    check("hyst_adapt", 3'd2, 1'b0, 8'd0);

    diverge_seq("diverge", 8'd1);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
`ifdef NC_DIVERGE_RESTART_EN
    check("after_div", 3'd1, 1'b0, 8'd1);
`else
    check("hold_sticky", 3'd4, 1'b0, 8'd1);
`endif

    // enable drop beats the strobe that would complete convergence
    cyc(1'b0, 1'b0, 1'b0, 16'sd0);
    check("en_low_idle", 3'd0, 1'b0, 8'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0);
    check("reenter_warm", 3'd1, 1'b1, 8'd1);
    avg_m = '0;
    repeat (32) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
    check("reenter_adapt", 3'd2, 1'b0, 8'd1);
    repeat (63) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
    check("conv_63", 3'd2, 1'b0, 8'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'sd0);
    check("en_drop", 3'd0, 1'b0, 8'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'sd0);
    check("en_drop_stay", 3'd0, 1'b0, 8'd1);

    // reset while tracking
    cyc(1'b0, 1'b1, 1'b0, 16'sd0);
    repeat (32) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
    repeat (64) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
    check("pre_rst_track", 3'd3, 1'b0, 8'd1);
    cyc(1'b1, 1'b1, 1'b1, 16'sd0);
    check("rst_mid", 3'd0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0);
    check("post_rst_warm", 3'd1, 1'b1, 8'd0);

`ifdef NC_DIVERGE_RESTART_EN
    for (int k = 0; k < 260; k++) begin
      avg_m = '0;
      repeat (32) cyc(1'b0, 1'b1, 1'b1, 16'sd0);
      diverge_seq($sformatf("sat%0d", k), (k + 1 > 255) ? 8'd255 : 8'(k + 1));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
